// File: rtl/alu_pkg.sv
// Shared types and defaults for the arbitrated ALU block.
// Holds the op encoding, arbiter state enum and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the arbiter.
// slave side faces the arbiter, master side faces the requesters.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0][1:0]       req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic [7:0]            op_count;

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_result,
    output rsp_zero,
    output op_count
  );

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_result,
    input  rsp_zero,
    input  op_count
  );

endinterface

// File: rtl/alu_arbiter_main.sv
// Combinational ALU: AND / OR / ADD / SUB, modulo 2^WIDTH.
// Carry and borrow are dropped by the result width.
module ALU_main
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared ALU.
// IDLE grants, EXEC computes from captured operands, RESP holds.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [1:0]       w_grant;
  logic             w_sel;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             r_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_op_t          r_op;
  logic             r_id;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_id;
  logic [7:0]       r_op_count;

  // On contention the port not served last wins.
  always_comb begin
    w_grant = 2'b00;
    unique case (bus.req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_sel    = w_grant[1];
  assign w_accept = (r_state == ST_IDLE) && (|bus.req_valid);
  assign w_rsp_hs = (r_state == ST_RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (|bus.req_valid) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  ALU_main #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= ALU_AND;
      r_id <= 1'b0;
    end else if (w_accept) begin
      r_a <= bus.req_a[w_sel];
      r_b <= bus.req_b[w_sel];
      r_op <= alu_op_t'(bus.req_op[w_sel]);
      r_id <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_id <= 1'b0;
      r_last <= 1'b1;
      r_op_count <= 8'd0;
    end else begin
      if (r_state == ST_EXEC) begin
        r_rsp_result <= w_alu_res;
        r_rsp_zero <= ~|w_alu_res;
        r_rsp_id <= r_id;
      end
      if (w_rsp_hs) begin
        r_last <= r_rsp_id;
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE) ? w_grant : 2'b00;
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter against a transaction model.
// Directed scenarios followed by randomized transactions.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_last;
  int   m_count;
  int   acc_q[$];

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(posedge clk)
    if (!rst && |(bus.req_valid & bus.req_ready))
      acc_q.push_back(cyc);

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int ref_alu(int a, int b, int op);
    int m;
    m = (1 << W);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return (a + b) % m;
      default: return (a - b + m) % m;
    endcase
  endfunction

  function automatic int ref_grant(int v, int last);
    if (v == 3) return (last == 0) ? 1 : 0;
    if (v == 2) return 1;
    if (v == 1) return 0;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_port(int p, bit v, int a, int b, int op);
    bus.req_valid[p] = v;
    bus.req_a[p] = W'(a);
    bus.req_b[p] = W'(b);
    bus.req_op[p] = 2'(op);
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    for (int p = 0; p < 2; p++)
      set_port(p, 1'b0, $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    m_last = 1;
    m_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    set_port(0, 1'b1, 5, 3, 2);
    set_port(1, 1'b1, 7, 1, 3);
    tick();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b expected 0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_result !== 4'h0 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp: got %h/%b/%b expected 0/0/0",
               bus.rsp_result, bus.rsp_zero, bus.rsp_id);
    end
    checks++;
    if (bus.op_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_count: got %0d expected 0", bus.op_count);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready: got %b expected 00", bus.req_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: got %b expected 0", bus.rsp_valid);
    end
    m_last = 1;
    m_count = 0;
  endtask

  task automatic test_single();
    set_port(0, 1'b1, 'hA, 'h6, 0);
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", bus.req_ready);
    end
    tick();
    set_port(0, 1'b0, 'hF, 'hF, 1);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_exec: got v=%b r=%b expected v=0 r=00",
               bus.rsp_valid, bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h2 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: got v=%b r=%h z=%b id=%b expected 1/2/0/0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    m_last = 0;
    m_count++;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL single_done: got v=%b cnt=%0d expected 0/%0d",
               bus.rsp_valid, bus.op_count, m_count);
    end
  endtask

  task automatic test_contention();
    do_reset();
    set_port(0, 1'b1, 'hA, 'h6, 2);
    set_port(1, 1'b1, 'hA, 'h6, 1);
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL cont_grant0: got %b expected 01", bus.req_ready);
    end
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL cont_exec: got %b expected 00", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_result !== 4'h0 || bus.rsp_zero !== 1'b1 ||
        bus.rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL cont_rsp0: got %h/%b/%b expected 0/1/0",
               bus.rsp_result, bus.rsp_zero, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL cont_grant1: got %b expected 10", bus.req_ready);
    end
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    checks++;
    if (bus.rsp_result !== 4'hE || bus.rsp_zero !== 1'b0 ||
        bus.rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL cont_rsp1: got %h/%b/%b expected e/0/1",
               bus.rsp_result, bus.rsp_zero, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    m_last = 1;
    m_count = 2;
  endtask

  task automatic test_back_to_back();
    int a0, b0, o0, a1, b1, o1, eid, exp, resp;
    do_reset();
    a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
    o0 = $urandom_range(0, 3);
    a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
    o1 = $urandom_range(0, 3);
    acc_q.delete();
    set_port(0, 1'b1, a0, b0, o0);
    set_port(1, 1'b1, a1, b1, o1);
    bus.rsp_ready = 1'b1;
    resp = 0;
    for (int c = 0; c < 40 && resp < 8; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        eid = ref_grant(3, m_last);
        exp = (eid == 0) ? ref_alu(a0, b0, o0) : ref_alu(a1, b1, o1);
        checks++;
        if (bus.rsp_id !== 1'(eid) || eid != resp % 2 ||
            bus.rsp_result !== W'(exp)) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got id=%b r=%h expected id=%0d r=%h",
                   resp, bus.rsp_id, bus.rsp_result, eid, exp);
        end
        m_last = eid;
        m_count++;
        resp++;
      end
    end
    bus.req_valid = 2'b00;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (resp != 8 || acc_q.size() < 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d rsp %0d acc expected 8",
               resp, acc_q.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (acc_q[i] - acc_q[i-1] != 3) begin
          errors++;
          $display("FAIL b2b_interval%0d: got %0d expected 3",
                   i, acc_q[i] - acc_q[i-1]);
        end
      end
    end
    checks++;
    if (bus.op_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL b2b_opcount: got %0d expected %0d",
               bus.op_count, m_count);
    end
  endtask

  task automatic test_backpressure();
    set_port(0, 1'b1, 'hA, 'h6, 3);
    bus.req_valid[1] = 1'b0;
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h4 ||
          bus.req_ready !== 2'b00 || bus.op_count !== 8'(m_count)) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b c=%0d exp 1/4/00/%0d",
                 i, bus.rsp_valid, bus.rsp_result, bus.req_ready,
                 bus.op_count, m_count);
      end
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    m_last = 0;
    m_count = (m_count + 1) % 256;
    checks++;
    if (bus.op_count !== 8'(m_count) || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got c=%0d v=%b expected %0d/0",
               bus.op_count, bus.rsp_valid, m_count);
    end
  endtask

  task automatic test_borrow_wrap();
    int a, b, op, exp;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = (i == 0) ? 3 : $urandom_range(0, 15);
      b = (i == 0) ? 5 : $urandom_range(0, 15);
      op = (i == 0) ? 3 : $urandom_range(0, 3);
      exp = ref_alu(a, b, op);
      set_port(0, 1'b1, a, b, op);
      tick();
      bus.req_valid[0] = 1'b0;
      tick();
      if (i == 0 || i % 37 == 0) begin
        checks++;
        if (bus.rsp_result !== W'(exp) || (i == 0 && exp != 'hE)) begin
          errors++;
          $display("FAIL wrap_res%0d: got %h expected %h",
                   i, bus.rsp_result, exp);
        end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      m_count = (m_count + 1) % 256;
      if (i == 254) begin
        checks++;
        if (bus.op_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d expected 255", bus.op_count);
        end
      end
    end
    m_last = 0;
    checks++;
    if (bus.op_count !== 8'(m_count) || m_count != 0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", bus.op_count);
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    set_port(0, 1'b1, 1, 2, 1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    set_port(1, 1'b1, 'hF, 'h5, 0);
    tick();
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== 8'd0) begin
      errors++;
      $display("FAIL rresp_clear: got v=%b c=%0d expected 0/0",
               bus.rsp_valid, bus.op_count);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rresp_norsp: got %b expected 0", bus.rsp_valid);
    end
    set_port(0, 1'b1, 2, 3, 2);
    set_port(1, 1'b1, 4, 4, 2);
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rresp_grant: got %b expected 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    m_last = 0;
    m_count = 1;
  endtask

  task automatic test_random();
    int v, g, exp, hold;
    int a[2], b[2], op[2];
    for (int t = 0; t < 40; t++) begin
      v = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        a[p] = $urandom_range(0, 15);
        b[p] = $urandom_range(0, 15);
        op[p] = $urandom_range(0, 3);
        set_port(p, v[p], a[p], b[p], op[p]);
      end
      g = ref_grant(v, m_last);
      exp = ref_alu(a[g], b[g], op[g]);
      #1;
      checks++;
      if (bus.req_ready !== 2'(1 << g)) begin
        errors++;
        $display("FAIL rnd_grant%0d: got %b expected %0d",
                 t, bus.req_ready, 1 << g);
      end
      tick();
      for (int p = 0; p < 2; p++)
        set_port(p, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 3));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      tick();
      bus.rsp_ready = 1'b0;
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(g) ||
            bus.rsp_result !== W'(exp) || bus.rsp_zero !== (exp == 0) ||
            bus.req_ready !== 2'b00) begin
          errors++;
          $display("FAIL rnd_rsp%0d: got v=%b id=%b r=%h z=%b exp id=%0d r=%h",
                   t, bus.rsp_valid, bus.rsp_id, bus.rsp_result,
                   bus.rsp_zero, g, exp);
        end
        if (h < hold) tick();
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      m_last = g;
      m_count = (m_count + 1) % 256;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.op_count !== 8'(m_count)) begin
        errors++;
        $display("FAIL rnd_done%0d: got v=%b c=%0d expected 0/%0d",
                 t, bus.rsp_valid, bus.op_count, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_backpressure();
    test_borrow_wrap();
    test_reset_in_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
